// File: rtl/atm_keypad_entry_if.sv
// Keypad-entry bundle: scanner inputs and the controller-facing digit/amount outputs.
// The scanner side (master) drives the key signals; the entry block (slave) drives the results.
interface atm_keypad_entry_if;
  logic        tecla_valida;
  logic [3:0]  tecla_codigo;
  logic        modo_monto;
  logic [3:0]  digito;
  logic        digito_stb;
  logic [31:0] monto;
  logic        monto_stb;
  logic        error_digitos;

  modport master (
    output tecla_valida, tecla_codigo, modo_monto,
    input  digito, digito_stb, monto, monto_stb, error_digitos
  );

  modport slave (
    input  tecla_valida, tecla_codigo, modo_monto,
    output digito, digito_stb, monto, monto_stb, error_digitos
  );
endinterface

// File: rtl/atm_keypad_entry.sv
// Debounces raw keypad scanner output into single key events, then either emits PIN digits
// or accumulates a decimal amount that is committed on ENTER.
module atm_keypad_entry #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned MAX_DIGITOS     = 9
) (
  input logic               clk,
  input logic               reset,
  atm_keypad_entry_if.slave kp
);

  localparam int unsigned NdigW    = $clog2(MAX_DIGITOS + 1);
  localparam logic [7:0]  DebLast  = 8'(DEBOUNCE_CYCLES - 1);
  localparam logic [3:0]  KeyEnter = 4'hA;
  localparam logic [3:0]  KeyClear = 4'hB;

  typedef enum logic [1:0] {StEspera, StPresion, StSostenida, StLiberacion} state_e;

  state_e      r_state, w_state_d;
  logic [3:0]  r_code, w_code_d;
  logic [7:0]  r_cnt, w_cnt_d;
  logic        w_accept;

  logic             r_modo;
  logic [31:0]      r_acc, w_acc_d, w_acc_base;
  logic [NdigW-1:0] r_ndig, w_ndig_d, w_ndig_base;
  logic [3:0]       r_digito, w_digito_d;
  logic [31:0]      r_monto, w_monto_d;
  logic             r_digito_stb, w_digito_stb_d;
  logic             r_monto_stb, w_monto_stb_d;
  logic             r_error, w_error_d;
  logic             w_mode_chg;

  // Debounce FSM: acceptance happens on the edge that would bring cnt to DEBOUNCE_CYCLES.
  always_comb begin
    w_state_d = r_state;
    w_code_d  = r_code;
    w_cnt_d   = r_cnt;
    w_accept  = 1'b0;
    unique case (r_state)
      StEspera: begin
        if (kp.tecla_valida) begin
          w_code_d  = kp.tecla_codigo;
          w_cnt_d   = 8'd1;
          w_state_d = StPresion;
        end
      end
      StPresion: begin
        if (!kp.tecla_valida) begin
          w_state_d = StEspera;
        end else if (kp.tecla_codigo != r_code) begin
          w_code_d = kp.tecla_codigo;
          w_cnt_d  = 8'd1;
        end else if (r_cnt == DebLast) begin
          w_accept  = 1'b1;
          w_state_d = StSostenida;
        end else begin
          w_cnt_d = r_cnt + 8'd1;
        end
      end
      StSostenida: begin
        if (!kp.tecla_valida) begin
          w_cnt_d   = 8'd1;
          w_state_d = StLiberacion;
        end
      end
      StLiberacion: begin
        if (kp.tecla_valida) begin
          w_state_d = StSostenida;
        end else if (r_cnt == DebLast) begin
          w_state_d = StEspera;
        end else begin
          w_cnt_d = r_cnt + 8'd1;
        end
      end
      default: w_state_d = StEspera;
    endcase
  end

  // A mode change wipes the amount first; a coinciding event then acts on the clean state.
  always_comb begin
    w_mode_chg     = (kp.modo_monto != r_modo);
    w_acc_base     = w_mode_chg ? 32'd0 : r_acc;
    w_ndig_base    = w_mode_chg ? '0 : r_ndig;
    w_acc_d        = w_acc_base;
    w_ndig_d       = w_ndig_base;
    w_digito_d     = r_digito;
    w_monto_d      = r_monto;
    w_digito_stb_d = 1'b0;
    w_monto_stb_d  = 1'b0;
    w_error_d      = 1'b0;
    if (w_accept) begin
      if (!kp.modo_monto) begin
        if (r_code <= 4'd9) begin
          w_digito_d     = r_code;
          w_digito_stb_d = 1'b1;
        end
      end else if (r_code <= 4'd9) begin
        if (w_ndig_base < NdigW'(MAX_DIGITOS)) begin
          w_acc_d  = {w_acc_base[28:0], 3'b000} + {w_acc_base[30:0], 1'b0} + {28'd0, r_code};
          w_ndig_d = w_ndig_base + NdigW'(1);
        end else begin
          w_error_d = 1'b1;
        end
      end else if (r_code == KeyEnter) begin
        if (w_ndig_base != '0) begin
          w_monto_d     = w_acc_base;
          w_monto_stb_d = 1'b1;
          w_acc_d       = 32'd0;
          w_ndig_d      = '0;
        end
      end else if (r_code == KeyClear) begin
        w_acc_d  = 32'd0;
        w_ndig_d = '0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= StEspera;
      r_code       <= 4'd0;
      r_cnt        <= 8'd0;
      r_modo       <= 1'b0;
      r_acc        <= 32'd0;
      r_ndig       <= '0;
      r_digito     <= 4'd0;
      r_monto      <= 32'd0;
      r_digito_stb <= 1'b0;
      r_monto_stb  <= 1'b0;
      r_error      <= 1'b0;
    end else begin
      r_state      <= w_state_d;
      r_code       <= w_code_d;
      r_cnt        <= w_cnt_d;
      r_modo       <= kp.modo_monto;
      r_acc        <= w_acc_d;
      r_ndig       <= w_ndig_d;
      r_digito     <= w_digito_d;
      r_monto      <= w_monto_d;
      r_digito_stb <= w_digito_stb_d;
      r_monto_stb  <= w_monto_stb_d;
      r_error      <= w_error_d;
    end
  end

  assign kp.digito        = r_digito;
  assign kp.digito_stb    = r_digito_stb;
  assign kp.monto         = r_monto;
  assign kp.monto_stb     = r_monto_stb;
  assign kp.error_digitos = r_error;

endmodule

// File: tb/tb_atm_keypad_entry.sv
// Directed bench for atm_keypad_entry: PIN digits, bounce rejection, amount entry,
// digit overflow, clear, mode change and mid-entry reset.
module tb_atm_keypad_entry;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   failures = 0;
  int   n_dstb = 0, n_mstb = 0, n_err = 0, n_viol = 0;
  int   base_d, base_m, base_e;
  logic prev_any = 1'b0;

  atm_keypad_entry_if kif ();

  atm_keypad_entry #(
    .DEBOUNCE_CYCLES(4),
    .MAX_DIGITOS    (9)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .kp   (kif.slave)
  );

  always #5 clk = ~clk;

  // Pulse counters and pulse-rule watcher, sampled mid-cycle.
  always @(negedge clk) begin
    if (kif.digito_stb) n_dstb++;
    if (kif.monto_stb) n_mstb++;
    if (kif.error_digitos) n_err++;
    if ((kif.digito_stb && kif.monto_stb) ||
        (prev_any && (kif.digito_stb || kif.monto_stb || kif.error_digitos))) n_viol++;
    prev_any = kif.digito_stb || kif.monto_stb || kif.error_digitos;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic key(input logic [3:0] c);
    @(posedge clk); #1;
    kif.tecla_valida = 1'b1;
    kif.tecla_codigo = c;
    repeat (6) @(posedge clk);
    #1 kif.tecla_valida = 1'b0;
    repeat (6) @(posedge clk);
    #1;
  endtask

  task automatic snap();
    base_d = n_dstb;
    base_m = n_mstb;
    base_e = n_err;
  endtask

  initial begin
    kif.tecla_valida = 1'b0;
    kif.tecla_codigo = 4'd0;
    kif.modo_monto   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_digito", 32'(kif.digito), 32'd0);
    chk("reset_monto", kif.monto, 32'd0);
    chk("reset_pulses", {29'd0, kif.digito_stb, kif.monto_stb, kif.error_digitos}, 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    // PIN key 7: pulse exactly after edge 4.
    snap();
    kif.tecla_valida = 1'b1;
    kif.tecla_codigo = 4'd7;
    repeat (3) @(posedge clk);
    #1 chk("pin7_edge3_stb", 32'(kif.digito_stb), 32'd0);
    @(posedge clk);
    #1 chk("pin7_edge4_stb", 32'(kif.digito_stb), 32'd1);
    chk("pin7_digito", 32'(kif.digito), 32'd7);
    @(posedge clk);
    #1 chk("pin7_edge5_stb", 32'(kif.digito_stb), 32'd0);
    repeat (5) @(posedge clk);
    #1 kif.tecla_valida = 1'b0;
    repeat (6) @(posedge clk);
    #1 chk("pin7_one_pulse", 32'(n_dstb - base_d), 32'd1);

    // PIN key 3 with bounce 1,0,1,1,0 then a stable hold.
    snap();
    kif.tecla_codigo = 4'd3;
    kif.tecla_valida = 1'b1; @(posedge clk);
    #1 kif.tecla_valida = 1'b0; @(posedge clk);
    #1 kif.tecla_valida = 1'b1; @(posedge clk);
    @(posedge clk);
    #1 kif.tecla_valida = 1'b0; @(posedge clk);
    #1 kif.tecla_valida = 1'b1;
    repeat (3) @(posedge clk);
    #1 chk("bounce_no_early", 32'(n_dstb - base_d + 32'(kif.digito_stb)), 32'd0);
    @(posedge clk);
    #1 chk("bounce_stb", 32'(kif.digito_stb), 32'd1);
    chk("bounce_digito", 32'(kif.digito), 32'd3);
    repeat (4) @(posedge clk);
    #1 kif.tecla_valida = 1'b0;
    repeat (6) @(posedge clk);
    #1 chk("bounce_one_pulse", 32'(n_dstb - base_d), 32'd1);

    // ENTER in PIN mode produces nothing.
    snap();
    key(4'hA);
    chk("pin_enter_ignored", 32'(n_dstb - base_d + n_mstb - base_m), 32'd0);

    // Amount 1,2,5,0 ENTER -> 1250.
    kif.modo_monto = 1'b1;
    snap();
    key(4'd1); key(4'd2); key(4'd5); key(4'd0); key(4'hA);
    chk("amt1250_monto", kif.monto, 32'h0000_04E2);
    chk("amt1250_mstb", 32'(n_mstb - base_m), 32'd1);
    chk("amt1250_no_dstb", 32'(n_dstb - base_d), 32'd0);
    chk("amt_digito_held", 32'(kif.digito), 32'd3);

    // Ten nines: error on the 10th only.
    snap();
    repeat (9) key(4'd9);
    chk("nines_no_err_yet", 32'(n_err - base_e), 32'd0);
    key(4'd9);
    chk("nines_err_once", 32'(n_err - base_e), 32'd1);
    key(4'hA);
    chk("nines_monto", kif.monto, 32'h3B9A_C9FF);

    // 4,2,BORRAR,8,ENTER -> 8; lone ENTER then ignored.
    snap();
    key(4'd4); key(4'd2); key(4'hB); key(4'd8); key(4'hA);
    chk("clear_monto", kif.monto, 32'd8);
    chk("clear_mstb", 32'(n_mstb - base_m), 32'd1);
    snap();
    key(4'hA);
    chk("lone_enter", 32'(n_mstb - base_m), 32'd0);

    // Mode toggle wipes a partial amount.
    snap();
    key(4'd3);
    kif.modo_monto = 1'b0; @(posedge clk);
    #1 kif.modo_monto = 1'b1; @(posedge clk);
    #1 key(4'hA);
    chk("modechg_clears", 32'(n_mstb - base_m), 32'd0);
    chk("modechg_monto", kif.monto, 32'd8);

    // Reset while a third key is held, then 6 ENTER.
    key(4'd5); key(4'd5);
    @(posedge clk); #1;
    kif.tecla_valida = 1'b1;
    kif.tecla_codigo = 4'd7;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    kif.tecla_valida = 1'b0;
    #1 chk("rst_mid_monto", kif.monto, 32'd0);
    chk("rst_mid_outs", {27'd0, kif.digito, kif.digito_stb},
        {27'd0, 4'd0, 1'b0});
    @(posedge clk);
    #1 chk("rst_mid_pulses", {30'd0, kif.monto_stb, kif.error_digitos}, 32'd0);
    reset = 1'b0;
    snap();
    key(4'd6); key(4'hA);
    chk("rst_after_monto", kif.monto, 32'd6);
    chk("rst_after_mstb", 32'(n_mstb - base_m), 32'd1);

    chk("pulse_rules", 32'(n_viol), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/atm_keypad_entry.md
Name: atm_keypad_entry

Overview:
- Upstream stage of the ATM controller. Turns raw keypad scanner output into clean, debounced key events.
- In PIN mode it emits one 4-bit digit plus a one-cycle digito_stb per accepted key press.
- In amount mode it accumulates decimal digits into a 32-bit binary amount and emits monto plus a one-cycle monto_stb on ENTER.
- Outputs connect directly to the controller's digito/digito_stb/monto/monto_stb inputs.

Parameters:
- DEBOUNCE_CYCLES, 4, consecutive stable samples required to accept a press or a release (legal range 2..255).
- MAX_DIGITOS, 9, maximum decimal digits accumulated for an amount (9 keeps 999999999 below 2^32).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- tecla_valida  input  1  scanner level; high while a key is held.
- tecla_codigo  input  4  key code: 0-9 are digits, 0xA is ENTER, 0xB is BORRAR (clear), 0xC-0xF are ignored.
- modo_monto  input  1  0 = PIN digit mode, 1 = amount accumulation mode.
- digito  output  4  last accepted digit (PIN mode); held between strobes.
- digito_stb  output  1  one-cycle pulse, digito valid.
- monto  output  32  last committed amount; held between strobes.
- monto_stb  output  1  one-cycle pulse, monto valid.
- error_digitos  output  1  one-cycle pulse when a digit is dropped because MAX_DIGITOS is already reached.

Behaviour:
- Reset (asynchronous, immediate):
  - FSM goes to ESPERA.
  - All outputs go to 0; debounce counter, digit counter and accumulator are cleared.
  - Reset mid-debounce or mid-amount discards everything; no strobe fires.
- Debounce FSM states:
  - ESPERA: on an edge sampling tecla_valida=1, latch tecla_codigo, set cnt=1 and go to PRESION.
  - PRESION:
    - tecla_valida=1 with code equal to the latched code: cnt++.
    - When cnt reaches DEBOUNCE_CYCLES at an edge, the press is accepted at that edge and the FSM goes to SOSTENIDA.
    - tecla_valida=0: return to ESPERA, no event.
    - Code differs from the latched code: relatch the new code and set cnt=1.
  - SOSTENIDA: stay while tecla_valida=1; code changes are ignored. When tecla_valida=0, set cnt=1 and go to LIBERACION.
  - LIBERACION:
    - tecla_valida=0: cnt++. At DEBOUNCE_CYCLES go to ESPERA.
    - tecla_valida=1: go back to SOSTENIDA (bounce; no new event).
- Event rule: exactly one event per physical press. Holding a key never repeats.
- Event action at the acceptance edge (all outputs registered; pulses are high for the single cycle after that edge):
  - PIN mode (modo_monto=0):
    - Digit: digito <= code, digito_stb=1.
    - ENTER, BORRAR and 0xC-0xF produce no output.
  - Amount mode (modo_monto=1):
    - Digit with ndig<MAX_DIGITOS: acc <= acc*10 + code (32-bit unsigned, no overflow possible), ndig++.
    - Digit with ndig==MAX_DIGITOS: acc is unchanged and error_digitos=1.
    - ENTER with ndig>=1: monto <= acc, monto_stb=1, acc<=0, ndig<=0.
    - ENTER with ndig==0: ignored, no strobe.
    - BORRAR: acc<=0, ndig<=0, no strobe.
    - 0xC-0xF: ignored.
- Mode change: any edge where modo_monto differs from its previous registered value clears acc and ndig. A pending debounce is not affected.
- An event that coincides with a mode change uses the new mode, applied after the clear.
- digito_stb, monto_stb and error_digitos are never high in consecutive cycles. digito_stb and monto_stb are never high together.
- Latency: with tecla_valida rising before edge 1 and a stable code, the pulse is high between edge DEBOUNCE_CYCLES and edge DEBOUNCE_CYCLES+1.
- Minimum spacing between events: 2*DEBOUNCE_CYCLES+1 cycles.

Test Plan:
- DEBOUNCE_CYCLES=4, modo_monto=0, key 7 held 10 cycles then released 6 cycles -> digito=7; digito_stb high exactly 1 cycle, after edge 4; no second pulse.
- PIN mode, key 3 bouncing (1,0,1,1,0 pattern) before a stable hold -> no pulse until 4 consecutive high samples; exactly one digito_stb with digito=3.
- Amount mode, keys 1,2,5,0 then ENTER -> monto=1250 (0x000004E2); monto_stb 1 cycle; digito_stb never asserted.
- Amount mode, 10 presses of 9 then ENTER -> error_digitos pulses once on the 10th press; monto=999999999 (0x3B9AC9FF).
- Amount mode, keys 4,2, BORRAR, 8, ENTER -> monto=8. ENTER alone afterwards -> no monto_stb.
- Amount mode, keys 5,5, assert reset for 1 cycle mid-hold of a third key, then ENTER after 1 digit 6 -> all outputs 0 during reset; monto=6.
